datagram_sender: RTL and testbench
==================================

Name: datagram_sender

Overview:
- Motherboard-side transmit stage of the inter-board link. It serializes one MESSAGE_SIZE-bit datagram into 6-bit chunks.
- Each chunk goes over the 4-phase req/ack handshake that the childboard receiver consumes.
- Inputs: one datagram per send_valid/send_ready transfer from game logic. Outputs: a board-to-board req line and a 6-bit data bus.
- The ack line from the childboard arrives asynchronously to clk.

Parameters:
- N, 48, datagram width in bits (set to MESSAGE_SIZE at instantiation)
- W, 6, chunk width; equals the physical data wire count
- SETUP_CYCLES, 2, clk cycles that data is held stable before req rises
- SYNC_STAGES, 2, flip-flop stages on the incoming ack
- TIMEOUT_CYCLES, 65535, max clk cycles waiting on any single ack edge

Ports:
- clk  input  1  system clock
- rst  input  1  reset
- send_valid  input  1  datagram offered
- send_data  input  N  datagram payload
- send_ready  output  1  high when idle; transfer occurs on send_valid & send_ready
- wire_ack  input  1  asynchronous ack from receiver
- wire_req  output  1  request to receiver, registered
- wire_data  output  W  current chunk, registered
- busy  output  1  a datagram is in flight
- link_err  output  1  sticky; set on ack timeout

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: wire_req=0, wire_data=0, busy=0, link_err=0, send_ready=1, state=IDLE, chunk index=0, sync chain=0.
- Reset mid-transfer: same values immediately. The partially sent datagram is discarded; the receiver must be reset in the same event.
- Chunk count C = ceil(N/W); 8 at default.
- Chunk order: chunk k = payload bits [k*W +: W], LSB chunk first. The top chunk is zero-padded above bit N-1.
- Payload capture: send_data is captured into a shift register on transfer and is not sampled again.
- ack_s = wire_ack after SYNC_STAGES flops. Only ack_s is used.
- IDLE: send_ready=1. On send_valid, latch payload, drive wire_data=chunk0, busy=1, go to SETUP.
- SETUP: wire_req stays 0 for SETUP_CYCLES cycles with wire_data stable. If ack_s=1 on entry (stale ack), hold in SETUP until ack_s=0. Then set wire_req=1 and go to WAIT_ACK_HI.
- WAIT_ACK_HI: on ack_s=1, set wire_req=0 and go to WAIT_ACK_LO. wire_data stays unchanged.
- WAIT_ACK_LO: on ack_s=0:
  - If this was the last chunk, go to IDLE next cycle with busy=0.
  - Otherwise advance the index, load the next chunk onto wire_data, go to SETUP.
- wire_data changes only in IDLE→SETUP and WAIT_ACK_LO→SETUP transitions, and never while wire_req=1 or ack_s=1.
- Timeout: a counter resets on every state entry and counts in WAIT_ACK_HI and WAIT_ACK_LO. When it reaches TIMEOUT_CYCLES:
  - set link_err=1 (sticky until rst) and force wire_req=0;
  - wait for ack_s=0, then go to IDLE with the datagram dropped.
- send_valid while busy: ignored. The upstream must hold the datagram until send_ready.
- Back-to-back: send_ready is high for at least 1 cycle between datagrams.
- Per-chunk minimum time = SETUP_CYCLES + 1 + 2 round trips through SYNC_STAGES.

Decomposition:
- Shared constants.svh: MESSAGE_SIZE, CHUNK_W=6, and a typedef enum sender_state_t {IDLE, SETUP, WAIT_ACK_HI, WAIT_ACK_LO, RECOVER}.
- One sub-module, sync_ff (parameter STAGES, async rst to 0), used for ack. The same sub-module is reusable on the receiver's req input.

Test Plan:
- Nominal send: responder model acks 3 cycles after req, 48'h123456789ABC sent → 8 req pulses; wire_data sequence 0x3C,0x2A,0x09,0x1E,0x16,0x11,0x23,0x04; busy falls after the 8th ack drops; send_ready=1.
- Stability: random ack delay 1–20 cycles → wire_data never changes while wire_req=1 or ack_s=1; wire_req never rises with less than SETUP_CYCLES of stable data.
- Back-to-back with busy: 48'hFFFFFFFFFFFF then 48'h0, send_valid held high throughout → second datagram accepted only after the first completes; chunks all 0x3F then all 0x00; no chunk lost.
- Timeout: responder never acks, TIMEOUT_CYCLES=16 → link_err=1 after 16 cycles in WAIT_ACK_HI, wire_req=0, return to IDLE; a later datagram still sends while link_err stays 1.
- Reset mid-op: assert rst during chunk 3 with wire_req=1 → wire_req=0 and wire_data=0 asynchronously; after release, a fresh datagram sends chunk 0 first.
- Stale ack: hold wire_ack=1 when send_valid arrives → no req until ack is low, then normal transfer.

Source files
------------

// File: rtl/datagram_sender_pkg.sv
// Shared definitions for the inter-board datagram transmit stage.
//   MESSAGE_SIZE   : datagram width exchanged with the childboard
//   CHUNK_W        : physical data wire count of the link
//   sender_state_t : transmit FSM states
//   chunk_count()  : number of W-bit chunks needed to carry N bits
package datagram_sender_pkg;

  localparam int unsigned MESSAGE_SIZE = 48;
  localparam int unsigned CHUNK_W      = 6;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT_ACK_HI,
    WAIT_ACK_LO,
    RECOVER
  } sender_state_t;

  function automatic int unsigned chunk_count(input int unsigned n, input int unsigned w);
    return (n + w - 1) / w;
  endfunction

endpackage

// File: rtl/datagram_sender_sync_ff.sv
// Multi-stage synchronizer for a single asynchronous control line.
// Used on the ack input of the sender; equally usable on the receiver's
// req input.
//   clk : destination clock
//   rst : asynchronous active-high reset, clears the chain to 0
//   d   : asynchronous input
//   q   : input after STAGES flops
module datagram_sender_sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/datagram_sender.sv
// Motherboard transmit stage of the inter-board link. Serializes one
// N-bit datagram into W-bit chunks (LSB chunk first) and sends each one
// over a 4-phase req/ack handshake.
//   clk, rst   : system clock, asynchronous active-high reset
//   send_valid : datagram offered by game logic
//   send_data  : datagram payload, captured once on transfer
//   send_ready : high in IDLE; transfer on send_valid & send_ready
//   wire_ack   : asynchronous ack from the childboard receiver
//   wire_req   : registered request to the receiver
//   wire_data  : registered current chunk
//   busy       : a datagram is in flight
//   link_err   : sticky ack-timeout flag, cleared only by rst
module datagram_sender
  import datagram_sender_pkg::*;
#(
  parameter int unsigned N              = MESSAGE_SIZE,
  parameter int unsigned W              = CHUNK_W,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         send_valid,
  input  logic [N-1:0] send_data,
  output logic         send_ready,
  input  logic         wire_ack,
  output logic         wire_req,
  output logic [W-1:0] wire_data,
  output logic         busy,
  output logic         link_err
);

  localparam int unsigned C   = chunk_count(N, W);
  localparam int unsigned SW  = C * W;
  localparam int unsigned IW  = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned SCW = $clog2(SETUP_CYCLES + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES + 1);

  logic          ack_s;
  sender_state_t state, state_nxt;
  logic [SW-1:0] shreg, shreg_nxt;
  logic [SW-1:0] payload;
  logic [IW-1:0] idx, idx_nxt;
  logic [SCW-1:0] setup_cnt, setup_cnt_nxt;
  logic [TW-1:0] to_cnt, to_cnt_nxt;
  logic [W-1:0]  data_nxt;
  logic          req_nxt, busy_nxt, err_nxt;

  datagram_sender_sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (wire_ack),
    .q   (ack_s)
  );

  // Zero-pads the top chunk above bit N-1.
  assign payload    = SW'(send_data);
  assign send_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      idx       <= '0;
      setup_cnt <= '0;
      to_cnt    <= '0;
      wire_data <= '0;
      wire_req  <= 1'b0;
      busy      <= 1'b0;
      link_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      idx       <= idx_nxt;
      setup_cnt <= setup_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      wire_data <= data_nxt;
      wire_req  <= req_nxt;
      busy      <= busy_nxt;
      link_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    idx_nxt       = idx;
    setup_cnt_nxt = setup_cnt;
    to_cnt_nxt    = to_cnt;
    data_nxt      = wire_data;
    req_nxt       = wire_req;
    busy_nxt      = busy;
    err_nxt       = link_err;

    case (state)
      IDLE: begin
        if (send_valid) begin
          // shreg holds the chunks still to be sent; chunk 0 goes straight out.
          shreg_nxt     = payload >> W;
          data_nxt      = payload[W-1:0];
          idx_nxt       = '0;
          setup_cnt_nxt = '0;
          busy_nxt      = 1'b1;
          state_nxt     = SETUP;
        end
      end

      SETUP: begin
        // A stale high ack restarts the setup window, so req only rises after
        // SETUP_CYCLES consecutive cycles of stable data with ack low.
        if (ack_s) begin
          setup_cnt_nxt = '0;
        end else if (setup_cnt == SCW'(SETUP_CYCLES - 1)) begin
          req_nxt    = 1'b1;
          to_cnt_nxt = '0;
          state_nxt  = WAIT_ACK_HI;
        end else begin
          setup_cnt_nxt = setup_cnt + 1'b1;
        end
      end

      WAIT_ACK_HI: begin
        if (ack_s) begin
          req_nxt    = 1'b0;
          to_cnt_nxt = '0;
          state_nxt  = WAIT_ACK_LO;
        end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          err_nxt   = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = RECOVER;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end

      WAIT_ACK_LO: begin
        if (!ack_s) begin
          if (idx == IW'(C - 1)) begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end else begin
            idx_nxt       = idx + 1'b1;
            data_nxt      = shreg[W-1:0];
            shreg_nxt     = shreg >> W;
            setup_cnt_nxt = '0;
            state_nxt     = SETUP;
          end
        end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          err_nxt   = 1'b1;
          req_nxt   = 1'b0;
          state_nxt = RECOVER;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end

      RECOVER: begin
        if (!ack_s) begin
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_datagram_sender.sv
module tb_datagram_sender;

  localparam int unsigned N     = 48;
  localparam int unsigned W     = 6;
  localparam int unsigned C     = 8;
  localparam int unsigned SETUP = 2;

  logic clk = 1'b0;
  logic rst;

  // main instance, default timeout
  logic         send_valid, send_ready, wire_ack, wire_req, busy, link_err;
  logic [N-1:0] send_data;
  logic [W-1:0] wire_data;

  // short-timeout instance
  logic         send_valid2, send_ready2, wire_req2, busy2, link_err2;
  logic         ack2 = 1'b0;
  logic [N-1:0] send_data2;
  logic [W-1:0] wire_data2;
  logic         en2;

  // responder for main instance
  logic resp_en, rand_dly, man_ack;
  logic resp_ack = 1'b0;
  assign wire_ack = resp_en ? resp_ack : man_ack;

  int checks = 0;
  int errors = 0;

  datagram_sender dut (
    .clk(clk), .rst(rst), .send_valid(send_valid), .send_data(send_data),
    .send_ready(send_ready), .wire_ack(wire_ack), .wire_req(wire_req),
    .wire_data(wire_data), .busy(busy), .link_err(link_err)
  );

  datagram_sender #(.TIMEOUT_CYCLES(16)) dut_to (
    .clk(clk), .rst(rst), .send_valid(send_valid2), .send_data(send_data2),
    .send_ready(send_ready2), .wire_ack(ack2), .wire_req(wire_req2),
    .wire_data(wire_data2), .busy(busy2), .link_err(link_err2)
  );

  always #5 clk = ~clk;

  function automatic int unsigned dly();
    return rand_dly ? $urandom_range(20, 1) : 3;
  endfunction

  always begin
    @(negedge clk);
    if (!resp_en) resp_ack = 1'b0;
    else if (wire_req && !resp_ack) begin
      repeat (dly()) @(negedge clk);
      resp_ack = 1'b1;
    end else if (!wire_req && resp_ack) begin
      repeat (dly()) @(negedge clk);
      resp_ack = 1'b0;
    end
  end

  always @(negedge clk) ack2 <= en2 & wire_req2;

  // reference view of the synchronized ack
  logic [1:0] ack_m;
  always @(posedge clk or posedge rst)
    if (rst) ack_m <= '0;
    else     ack_m <= {ack_m[0], wire_ack};

  // link monitor: chunk log and handshake-rule violations
  logic [W-1:0] got[$];
  logic [W-1:0] prev_data;
  logic         prev_req, prev_acks, prev_busy;
  int           stable;
  int           viol_data = 0;
  int           viol_setup = 0;
  always @(negedge clk) begin
    if (rst) begin
      got.delete();
      prev_data <= '0; prev_req <= 1'b0; prev_acks <= 1'b0; prev_busy <= 1'b0;
      stable <= 0;
    end else begin
      if (wire_data !== prev_data && prev_busy && busy &&
          (prev_req || wire_req || prev_acks))
        viol_data <= viol_data + 1;
      if (wire_req && !prev_req) begin
        if (wire_data !== prev_data || stable + 1 < SETUP) viol_setup <= viol_setup + 1;
        got.push_back(wire_data);
      end
      stable    <= (wire_data !== prev_data) ? 0 : stable + 1;
      prev_data <= wire_data;
      prev_req  <= wire_req;
      prev_acks <= ack_m[1];
      prev_busy <= busy;
    end
  end

  logic prev_req2 = 1'b0;
  int   pulses2 = 0;
  always @(negedge clk) begin
    prev_req2 <= wire_req2;
    if (wire_req2 && !prev_req2) pulses2 <= pulses2 + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expire(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=bound-expired expected=event", tag);
  endtask

  function automatic logic [63:0] chunk_of(input logic [N-1:0] p, input int k);
    return 64'((p >> (W * k)) & 48'h3F);
  endfunction

  task automatic check_chunks(input string tag, input logic [N-1:0] p, input int base);
    for (int k = 0; k < C; k++)
      if (base + k < got.size())
        check($sformatf("%s_chunk%0d", tag, k), 64'(got[base+k]), chunk_of(p, k));
  endtask

  task automatic start_send(input logic [N-1:0] p);
    int n = 0;
    while (!send_ready && n < 5000) begin @(negedge clk); n++; end
    if (!send_ready) expire("start_ready");
    send_valid = 1'b1;
    send_data  = p;
    @(negedge clk);
    send_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    if (busy) expire(tag);
  endtask

  initial begin
    logic [N-1:0] p;
    logic [63:0]  r;
    int base, n, hi, p0;

    rst = 1'b1; send_valid = 1'b0; send_data = '0; send_valid2 = 1'b0; send_data2 = '0;
    resp_en = 1'b1; rand_dly = 1'b0; man_ack = 1'b0; en2 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req", wire_req, 0);
    check("rst_data", wire_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", link_err, 0);
    check("rst_ready", send_ready, 1);
    check("rst_err2", link_err2, 0);
    check("rst_ready2", send_ready2, 1);
    rst = 1'b0;
    @(negedge clk);

    // nominal send
    p = 48'h123456789ABC;
    base = got.size();
    start_send(p);
    wait_idle("nom_done");
    check("nom_count", got.size(), base + C);
    check_chunks("nom", p, base);
    check("nom_ready", send_ready, 1);
    check("nom_req", wire_req, 0);
    check("nom_err", link_err, 0);

    // random payloads, random ack delays
    rand_dly = 1'b1;
    for (int i = 0; i < 5; i++) begin
      r = {$urandom, $urandom};
      p = r[N-1:0];
      base = got.size();
      start_send(p);
      wait_idle("rnd_done");
      check($sformatf("rnd%0d_count", i), got.size(), base + C);
      check_chunks($sformatf("rnd%0d", i), p, base);
    end
    rand_dly = 1'b0;

    // back-to-back with send_valid held
    n = 0;
    while (!send_ready && n < 5000) begin @(negedge clk); n++; end
    base = got.size();
    send_valid = 1'b1;
    send_data  = '1;
    n = 0;
    while (!busy && n < 50) begin @(negedge clk); n++; end
    if (!busy) expire("b2b_start");
    send_data = '0;
    n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    if (busy) expire("b2b_first_done");
    check("b2b_first_count", got.size(), base + C);
    check("b2b_gap_ready", send_ready, 1);
    @(negedge clk);
    check("b2b_second_accept", busy, 1);
    send_valid = 1'b0;
    wait_idle("b2b_second_done");
    check("b2b_count", got.size(), base + 2 * C);
    check_chunks("b2b_ones", '1, base);
    check_chunks("b2b_zeros", '0, base + C);

    // stale ack held high when the datagram arrives
    resp_en = 1'b0;
    man_ack = 1'b1;
    repeat (5) @(negedge clk);
    p = 48'hA5C3_0F1E_7B29;
    base = got.size();
    start_send(p);
    repeat (12) @(negedge clk);
    check("stale_no_req", wire_req, 0);
    check("stale_busy", busy, 1);
    check("stale_no_chunk", got.size(), base);
    man_ack = 1'b0;
    resp_en = 1'b1;
    wait_idle("stale_done");
    check("stale_count", got.size(), base + C);
    check_chunks("stale", p, base);

    // reset during chunk 3 with req high
    p = 48'hDEAD_BEEF_CAFE;
    base = got.size();
    start_send(p);
    n = 0;
    while (!(got.size() == base + 4 && wire_req) && n < 5000) begin @(negedge clk); n++; end
    if (!(got.size() == base + 4 && wire_req)) expire("mid_reach_chunk3");
    #1 rst = 1'b1;
    #1;
    check("mid_req", wire_req, 0);
    check("mid_data", wire_data, 0);
    check("mid_busy", busy, 0);
    check("mid_ready", send_ready, 1);
    resp_en = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    resp_en = 1'b1;
    @(negedge clk);
    p = 48'h0123_4567_89AB;
    base = got.size();
    start_send(p);
    wait_idle("mid_fresh_done");
    check("mid_fresh_count", got.size(), base + C);
    check_chunks("mid_fresh", p, base);

    // timeout on the short-timeout instance, ack never arrives
    p = 48'h1357_9BDF_2468;
    send_valid2 = 1'b1;
    send_data2  = p;
    @(negedge clk);
    send_valid2 = 1'b0;
    n = 0;
    while (!wire_req2 && n < 50) begin @(negedge clk); n++; end
    if (!wire_req2) expire("to_req_rise");
    hi = 0;
    while (wire_req2 && hi < 100) begin hi++; @(negedge clk); end
    check("to_req_cycles", hi, 16);
    check("to_err_set", link_err2, 1);
    check("to_req_low", wire_req2, 0);
    n = 0;
    while (busy2 && n < 50) begin @(negedge clk); n++; end
    if (busy2) expire("to_idle");
    check("to_ready", send_ready2, 1);
    en2 = 1'b1;
    p0 = pulses2;
    @(negedge clk);
    send_valid2 = 1'b1;
    @(negedge clk);
    send_valid2 = 1'b0;
    n = 0;
    while (busy2 && n < 2000) begin @(negedge clk); n++; end
    if (busy2) expire("to_resend_done");
    check("to_resend_pulses", pulses2 - p0, C);
    check("to_err_sticky", link_err2, 1);
    check("to_lastdata", 64'(wire_data2), chunk_of(p, C - 1));

    check("data_stable", viol_data, 0);
    check("setup_time", viol_setup, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
